// File: rtl/oled_spi_pkg.sv
// Types and constants shared by both ends of the OLED serial link.
package oled_spi_pkg;

  parameter int unsigned SPI_BITS = 8;

  typedef struct packed {
    logic       dc;
    logic [7:0] data;
  } rx_word_t;

  parameter logic SCLK_IDLE = 1'b1;

endpackage

// File: rtl/spi_rx_sync.sv
// Multi-flop synchronizer with one extra delay flop for edge detection.
module spi_rx_sync #(
  parameter int unsigned Stages   = 2,
  parameter logic        ResetVal = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic [Stages-1:0] sync_q;
  logic              dly_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= {Stages{ResetVal}};
      dly_q  <= ResetVal;
    end else begin
      sync_q <= {sync_q[Stages-2:0], d_i};
      dly_q  <= sync_q[Stages-1];
    end
  end

  assign level_o = sync_q[Stages-1];
  assign rise_o  = sync_q[Stages-1] & ~dly_q;
  assign fall_o  = ~sync_q[Stages-1] & dly_q;

endmodule

// File: rtl/oled_spi_rx.sv
// OLED link receiver: oversampled SPI slave feeding a show-ahead FIFO of {dc, byte} words.
module oled_spi_rx
  import oled_spi_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned DEPTH       = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cs_n,
  input  logic       sclk,
  input  logic       sdi,
  input  logic       dc,
  input  logic       rd_ready,
  output logic       rd_valid,
  output logic [8:0] rd_data,
  output logic       busy,
  output logic       overrun,
  output logic       frame_err
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam int unsigned BitW = $clog2(SPI_BITS);
  localparam logic [BitW-1:0] LastBit = BitW'(SPI_BITS - 1);
  localparam logic [CntW-1:0] FullCnt = CntW'(DEPTH);

  logic sclk_s, sclk_rise, sclk_fall;
  logic cs_n_s, cs_rise, cs_fall;
  logic sdi_s, dc_s;
  logic [SYNC_STAGES-1:0] sdi_sync_q, dc_sync_q;
  logic unused_sync;

  spi_rx_sync #(
    .Stages   (SYNC_STAGES),
    .ResetVal (SCLK_IDLE)
  ) u_sclk_sync (
    .clk     (clk),
    .rst_n   (rst_n),
    .d_i     (sclk),
    .level_o (sclk_s),
    .rise_o  (sclk_rise),
    .fall_o  (sclk_fall)
  );

  spi_rx_sync #(
    .Stages   (SYNC_STAGES),
    .ResetVal (1'b1)
  ) u_cs_sync (
    .clk     (clk),
    .rst_n   (rst_n),
    .d_i     (cs_n),
    .level_o (cs_n_s),
    .rise_o  (cs_rise),
    .fall_o  (cs_fall)
  );

  assign unused_sync = sclk_s ^ sclk_fall ^ cs_fall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sdi_sync_q <= '0;
      dc_sync_q  <= '0;
    end else begin
      sdi_sync_q <= {sdi_sync_q[SYNC_STAGES-2:0], sdi};
      dc_sync_q  <= {dc_sync_q[SYNC_STAGES-2:0], dc};
    end
  end

  assign sdi_s = sdi_sync_q[SYNC_STAGES-1];
  assign dc_s  = dc_sync_q[SYNC_STAGES-1];

  // Shift register only holds the 7 earlier bits; the 8th goes straight into the FIFO.
  logic [SPI_BITS-2:0] shift_q, shift_d;
  logic [BitW-1:0]     bitcnt_q, bitcnt_d;
  logic                sample, complete, frame_err_d;

  // A rise coinciding with deselect still counts, so a finishing byte beats frame_err.
  assign sample   = sclk_rise & (~cs_n_s | cs_rise);
  assign complete = sample & (bitcnt_q == LastBit);

  always_comb begin
    shift_d     = shift_q;
    bitcnt_d    = bitcnt_q;
    frame_err_d = 1'b0;
    if (complete) begin
      shift_d  = {shift_q[SPI_BITS-3:0], sdi_s};
      bitcnt_d = '0;
    end else if (cs_rise) begin
      frame_err_d = (bitcnt_q != '0);
      shift_d     = '0;
      bitcnt_d    = '0;
    end else if (sample) begin
      shift_d  = {shift_q[SPI_BITS-3:0], sdi_s};
      bitcnt_d = bitcnt_q + 1'b1;
    end
  end

  rx_word_t            mem_q [DEPTH];
  rx_word_t            push_word;
  logic [PtrW-1:0]     wptr_q, rptr_q;
  logic [CntW-1:0]     count_q;
  logic                full, pop, push, overrun_d;

  assign push_word = {dc_s, shift_q, sdi_s};
  assign rd_valid  = (count_q != '0);
  assign full      = (count_q == FullCnt);
  assign pop       = rd_valid & rd_ready;
  assign push      = complete & (~full | pop);
  assign overrun_d = complete & full & ~pop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_q   <= '0;
      bitcnt_q  <= '0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
      wptr_q    <= '0;
      rptr_q    <= '0;
      count_q   <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      shift_q   <= shift_d;
      bitcnt_q  <= bitcnt_d;
      frame_err <= frame_err_d;
      overrun   <= overrun_d;
      if (push) begin
        mem_q[wptr_q] <= push_word;
        wptr_q        <= wptr_q + 1'b1;
      end
      if (pop) begin
        rptr_q <= rptr_q + 1'b1;
      end
      if (push && !pop) begin
        count_q <= count_q + 1'b1;
      end else if (pop && !push) begin
        count_q <= count_q - 1'b1;
      end
    end
  end

  assign rd_data = mem_q[rptr_q];
  assign busy    = (bitcnt_q != '0);

endmodule

// File: doc/oled_spi_rx.md
Name: oled_spi_rx

Overview:
- SPI receiver, the far end of the OLED serial link.
- Oversamples an asynchronous serial stream (sclk idles high, data MSB-first, sampled on sclk rising edge) with the system clock.
- Assembles bytes and tags each with the D/C line, then buffers them in a small show-ahead FIFO for a downstream command decoder / display model.
- Used as the bench-side display model and as the loopback checker for the OLED transmit path.

Parameters:
- SYNC_STAGES, 2, flip-flop stages in each input synchronizer (min 2).
- DEPTH, 4, FIFO depth in words (power of two, >=2).

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset: asynchronous, active-low
- cs_n  in  1  async chip select, active low
- sclk  in  1  async serial clock, idle high
- sdi  in  1  async serial data
- dc  in  1  async data/command flag (1=data, 0=command)
- rd_ready  in  1  consumer accepts head word
- rd_valid  out  1  FIFO non-empty
- rd_data  out  9  {dc, byte[7:0]} at FIFO head
- busy  out  1  partial byte in progress (bit count != 0)
- overrun  out  1  one-cycle pulse: completed byte dropped, FIFO full
- frame_err  out  1  one-cycle pulse: cs_n rose mid-byte

Behaviour:
- Reset: all outputs 0; FIFO empty; shift reg 0; bit count 0; synchronizers cs_n=1, sclk=1, others 0.
- Inputs cs_n, sclk, sdi and dc each pass through SYNC_STAGES flops.
- sclk_s and cs_n_s also get one more delay flop for edge detection.
- rise = sclk_s & !sclk_q.
- cs_rise = cs_n_s & !cs_n_q.
- Timing requirement: sclk high and low phases each >= SYNC_STAGES+2 clk cycles. The transmitter at N=100 meets this. Behaviour below that limit is undefined.
- Sampling: on a cycle with rise && !cs_n_s:
  - shift <= {shift[6:0], sdi_s}
  - bitcnt <= bitcnt+1 (3-bit, wraps 7->0)
- Rise while cs_n_s high is ignored.
- Byte complete: a rise with bitcnt==7 pushes {dc_s, shift[6:0], sdi_s} to the FIFO on the same clock edge. dc is sampled at that 8th edge.
- Latency: rd_valid goes high the cycle after the push edge, i.e. SYNC_STAGES+2 clk cycles after the 8th sclk rising edge at the pin.
- Back-to-back bytes under one cs_n low need no gap; bitcnt restarts at 0.
- Deselect:
  - cs_rise with bitcnt!=0: frame_err pulses 1 cycle, shift and bitcnt clear, nothing is pushed.
  - cs_rise with bitcnt==0: silent.
- FIFO:
  - Show-ahead: rd_data is valid whenever rd_valid is high.
  - Pop = rd_valid & rd_ready.
  - rd_data is held stable while rd_valid=1 and rd_ready=0.
  - Occupancy counter is width clog2(DEPTH)+1; pointers wrap modulo DEPTH.
- Full + push, no pop: word dropped, overrun pulses 1 cycle, FIFO contents and pointers unchanged.
- Full + push + pop in the same cycle: both occur, count unchanged, no overrun.
- Empty + push: rd_valid=0 that cycle, so rd_ready is ignored and no pop occurs.
- overrun and frame_err never both assert for the same byte. A cs_rise in the same cycle as the completing rise is treated as a completed byte (push wins, no frame_err).
- rst_n asserted mid-byte or mid-read: immediate clear to reset values; the partial byte and FIFO contents are lost.

Decomposition:
- Package oled_spi_pkg:
  - SPI_BITS=8
  - typedef rx_word_t packed struct {logic dc; logic [7:0] data;}
  - constant SCLK_IDLE=1'b1
  - shared with the transmit side.
- Sub-module spi_rx_sync: SYNC_STAGES synchronizer plus delay flop, outputs level/rise/fall. Instantiated for sclk and cs_n. Plain synchronizers are used for sdi and dc.
- The FIFO stays inline.

Test Plan:
- cs_n low, send 0xA5 with dc=1 at 100-clk half period -> one push; rd_data=9'h1A5 with rd_valid within SYNC_STAGES+2 cycles of the 8th rising edge; busy low afterwards.
- Back-to-back 0x3C (dc=0) then 0xFF (dc=1), rd_ready=1 -> rd_data 9'h03C then 9'h1FF; no overrun, no frame_err.
- rd_ready=0, send 5 bytes 0x01..0x05 with DEPTH=4 -> 4 words held, overrun pulses exactly once at byte 5; drain returns 0x01..0x04 in order.
- With FIFO full, pop in the same cycle as the 5th byte completes -> count stays 4, no overrun, last word read is 0x05.
- 3 bits sent then cs_n raised -> frame_err pulses 1 cycle, no push; next full byte 0x81 is received intact.
- rst_n pulsed after 4 bits with 2 words queued -> rd_valid=0, busy=0; a subsequent byte 0x5A is received correctly.
